// File: rtl/bit_scan_pkg.sv
// bit_scan_pkg: shared state encodings and scan-mode constants for bit_scan.
package bit_scan_pkg;
  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;
  localparam logic MSB_FIRST = 1'b0;
  localparam logic LSB_FIRST = 1'b1;
endpackage

// File: rtl/bit_scan_prio_enc.sv
// prio_enc: combinational index of the highest set bit, with a found flag.
module prio_enc #(
  parameter int WIDTH_LOG = 4
) (
  input  logic [2**WIDTH_LOG-1:0] din,
  output logic [WIDTH_LOG-1:0]    idx,
  output logic                    found
);
  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int i = 0; i < 2**WIDTH_LOG; i++) begin
      if (din[i]) begin
        idx = WIDTH_LOG'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bit_scan.sv
// bit_scan: streams the index of every set bit of an accepted vector, one beat per cycle.
module bit_scan
  import bit_scan_pkg::*;
#(
  parameter int WIDTH_LOG = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2**WIDTH_LOG-1:0] in_data,
  input  logic                   in_lsb_first,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH_LOG-1:0]   out_idx,
  output logic [WIDTH_LOG:0]     out_seq,
  output logic                   out_last,
  output logic                   out_none
);
  localparam int WIDTH = 2**WIDTH_LOG;
  state_t               state_q, state_d;
  logic [WIDTH-1:0]     rem_q, rem_d, enc_in;
  logic                 mode_q, mode_d;
  logic [WIDTH_LOG:0]   seq_q, seq_d;
  logic [WIDTH_LOG-1:0] enc_idx;
  logic                 enc_found, fire, accept;
  // LSB mode reuses the MSB encoder on the bit-reversed vector
  always_comb begin
    enc_in = rem_q;
    for (int i = 0; i < WIDTH; i++) enc_in[i] = (mode_q == LSB_FIRST) ? rem_q[WIDTH-1-i] : rem_q[i];
  end
  prio_enc #(.WIDTH_LOG(WIDTH_LOG)) u_enc (
    .din  (enc_in),
    .idx  (enc_idx),
    .found(enc_found)
  );
  always_comb begin
    out_valid = (state_q == SCAN);
    out_none  = out_valid && !enc_found;
    out_idx   = !enc_found ? '0 : (mode_q == LSB_FIRST) ? WIDTH_LOG'(WIDTH-1) - enc_idx : enc_idx;
    out_last  = out_valid && ((rem_q & (rem_q - WIDTH'(1))) == '0);
    out_seq   = seq_q;
    fire      = out_valid && out_ready;
    in_ready  = (state_q == IDLE) || (fire && out_last && !flush);
    accept    = in_valid && in_ready && !flush;
  end
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    seq_d   = seq_q;
    if (flush) begin
      state_d = IDLE;
      rem_d   = '0;
      seq_d   = '0;
    end else if (accept) begin
      state_d = SCAN;
      rem_d   = in_data;
      mode_d  = in_lsb_first;
      seq_d   = '0;
    end else if (fire) begin
      state_d = out_last ? IDLE : SCAN;
      rem_d   = rem_q & ~(WIDTH'(1) << out_idx);
      seq_d   = out_last ? '0 : seq_q + (WIDTH_LOG+1)'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      mode_q  <= MSB_FIRST;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      seq_q   <= seq_d;
    end
  end
endmodule
